// File: rtl/bus_mem_responder_pkg.sv
// Shared request/response types and helpers for the valid/ready memory bus.
// Used by the responder and by bus agents that talk to it.
package bus_mem_responder_pkg;

    localparam int unsigned BusAddrWidth = 32;
    localparam int unsigned BusDataWidth = 32;
    localparam int unsigned BusStrbWidth = BusDataWidth / 8;
    // Widest byte-enable vector is_write() accepts; narrower masks are zero-extended.
    localparam int unsigned MaxStrbWidth = 64;

    typedef struct packed {
        logic [BusAddrWidth-1:0] addr;
        logic [BusDataWidth-1:0] wdata;
        logic [BusStrbWidth-1:0] wmask;
    } bus_req_t;

    typedef struct packed {
        logic [BusDataWidth-1:0] rdata;
    } bus_rsp_t;

    function automatic logic is_write(input logic [MaxStrbWidth-1:0] wmask);
        return |wmask;
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Valid/ready request bus with single-cycle rvalid read return.
// The requester uses the master modport, the memory responder the slave modport.
interface bus_mem_responder_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   valid;
    logic                   ready;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wmask;
    logic [DataWidth-1:0]   rdata;
    logic                   rvalid;

    modport master (
        output valid, addr, wdata, wmask,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  valid, addr, wdata, wmask,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/bus_mem_responder_delay.sv
// Fixed-latency response delay line of {valid, data}; only the valid bits and the
// output data register are reset, internal data stages are plain flops.
module bus_resp_delay #(
    parameter int unsigned Width   = 32,
    parameter int unsigned Latency = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Latency-1:0] vld_q, vld_d;
    logic [Width-1:0]   out_q;
    logic [Width-1:0]   out_src;
    logic               out_load;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = valid_i;
        for (int i = 1; i < Latency; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    if (Latency == 1) begin : g_direct
        assign out_src  = data_i;
        assign out_load = valid_i;
    end else begin : g_pipe
        logic [Width-1:0] pipe_q [Latency-1];

        always_ff @(posedge clk_i) begin
            pipe_q[0] <= data_i;
            for (int i = 1; i < Latency - 1; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign out_src  = pipe_q[Latency-2];
        assign out_load = vld_q[Latency-2];
    end

    // Output data only moves with a response so it holds its last value while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else if (out_load) begin
            out_q <= out_src;
        end
    end

    assign valid_o = vld_q[Latency-1];
    assign data_o  = out_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Byte-maskable word memory on the responder side of the request bus, returning one
// in-order rvalid response per accepted request after a fixed latency.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned Depth          = 1024,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 4,
    parameter string       MemInitFile    = ""
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    bus_mem_responder_if.slave     bus
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [IdxW-1:0]      idx;
    logic                 ready, accept, wr, rvalid;
    logic [DataWidth-1:0] rsp_data, rdata;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 unused_addr;

    // Upper address bits beyond Depth wrap silently.
    assign idx         = bus.addr[OffW +: IdxW];
    assign unused_addr = ^bus.addr;

    assign ready    = rst_ni && ((cnt_q != CntMax) || rvalid);
    assign accept   = bus.valid && ready;
    assign wr       = is_write(MaxStrbWidth'(bus.wmask));
    assign rsp_data = wr ? '0 : mem_q[idx];

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int b = 0; b < StrbW; b++) begin
                if (bus.wmask[b]) begin
                    mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !rvalid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && rvalid) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    bus_resp_delay #(
        .Width   (DataWidth),
        .Latency (Latency)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (accept),
        .data_i  (rsp_data),
        .valid_o (rvalid),
        .data_o  (rdata)
    );

    assign bus.ready  = ready;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata;

    param_chk: assert property (@(posedge clk_i)
        (Latency >= 1) && (MaxOutstanding >= 1) && (DataWidth % 8 == 0) &&
        ((Depth & (Depth - 1)) == 0));
    cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CntMax);
    cnt_under: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((cnt_q == '0) && rvalid));

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: three instances with different latency/outstanding settings,
// driven through one request port and checked against a queue-based reference model.
module tb_bus_mem_responder;
    import bus_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned sel;
    logic        req_valid;
    bus_req_t    req;

    bus_mem_responder_if #(.AddrWidth(32), .DataWidth(32)) bus_a ();
    bus_mem_responder_if #(.AddrWidth(32), .DataWidth(32)) bus_b ();
    bus_mem_responder_if #(.AddrWidth(32), .DataWidth(32)) bus_c ();

    assign bus_a.valid = req_valid && (sel == 0);
    assign bus_b.valid = req_valid && (sel == 1);
    assign bus_c.valid = req_valid && (sel == 2);
    assign bus_a.addr = req.addr;   assign bus_a.wdata = req.wdata;   assign bus_a.wmask = req.wmask;
    assign bus_b.addr = req.addr;   assign bus_b.wdata = req.wdata;   assign bus_b.wmask = req.wmask;
    assign bus_c.addr = req.addr;   assign bus_c.wdata = req.wdata;   assign bus_c.wmask = req.wmask;

    bus_mem_responder #(.Latency(1), .MaxOutstanding(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
    bus_mem_responder #(.Latency(3), .MaxOutstanding(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b));
    bus_mem_responder #(.Latency(4), .MaxOutstanding(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_c));

    logic        obs_ready, obs_rvalid;
    logic [31:0] obs_rdata;
    always_comb begin
        obs_ready = bus_c.ready;  obs_rvalid = bus_c.rvalid;  obs_rdata = bus_c.rdata;
        if (sel == 0) begin
            obs_ready = bus_a.ready;  obs_rvalid = bus_a.rvalid;  obs_rdata = bus_a.rdata;
        end else if (sel == 1) begin
            obs_ready = bus_b.ready;  obs_rvalid = bus_b.rvalid;  obs_rdata = bus_b.rdata;
        end
    end

    // Reference model: pending responses with due cycle, plus byte-tracked memory image.
    typedef struct {
        int unsigned due;
        logic [31:0] data;
        bit          known;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [int];
    logic [3:0]  kmask_m [int];
    int unsigned cyc, lat_m, max_m;
    int unsigned n_cmp, n_fail, n_rsp;

    task automatic select_dut(input int unsigned s);
        sel = s;
        lat_m = (s == 0) ? 1 : (s == 1) ? 3 : 4;
        max_m = (s == 1) ? 2 : 4;
        exp_q.delete();
    endtask

    // One clock: check this cycle's outputs against the model, present a request, advance.
    task automatic step(input logic v, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, output bit acc);
        bit          resp_now, exp_ready;
        int          key;
        logic [31:0] w;
        exp_t        e;
        resp_now  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_ready = (exp_q.size() != max_m) || resp_now;
        n_cmp++;
        if (obs_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ready dut=%0d cyc=%0d got %b want %b", sel, cyc, obs_ready, exp_ready);
        end
        n_cmp++;
        if (obs_rvalid !== resp_now) begin
            n_fail++;
            $display("FAIL rvalid dut=%0d cyc=%0d got %b want %b", sel, cyc, obs_rvalid, resp_now);
        end
        if (resp_now) begin
            n_rsp++;
            if (exp_q[0].known) begin
                n_cmp++;
                if (obs_rdata !== exp_q[0].data) begin
                    n_fail++;
                    $display("FAIL rdata dut=%0d cyc=%0d got %h want %h", sel, cyc, obs_rdata,
                             exp_q[0].data);
                end
            end
            void'(exp_q.pop_front());
        end
        req_valid = v;
        req.addr  = addr;
        req.wdata = wdata;
        req.wmask = wmask;
        acc = v && exp_ready;
        if (acc) begin
            key   = int'(sel * 4096 + ((addr >> 2) & 32'd1023));
            e.due = cyc + lat_m;
            if (wmask != 4'h0) begin
                if (!mem_m.exists(key)) begin
                    mem_m[key]   = '0;
                    kmask_m[key] = '0;
                end
                w = mem_m[key];
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) begin
                        w[8*b +: 8] = wdata[8*b +: 8];
                        kmask_m[key][b] = 1'b1;
                    end
                end
                mem_m[key] = w;
                e.data  = '0;
                e.known = 1'b1;
            end else begin
                e.known = mem_m.exists(key) && (kmask_m[key] == 4'hF);
                e.data  = e.known ? mem_m[key] : '0;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, addr, wdata, wmask, acc);
        req_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL issue_timeout dut=%0d addr=%h got no accept want accept", sel, addr);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) step(1'b0, '0, '0, '0, acc);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout dut=%0d got %0d pending want 0", sel, exp_q.size());
        end
        step(1'b0, '0, '0, '0, acc);
    endtask

    task automatic test_reset();
        bit acc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_a.ready, bus_b.ready, bus_c.ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_ready got %b want 000", {bus_a.ready, bus_b.ready, bus_c.ready});
        end
        n_cmp++;
        if ({bus_a.rvalid, bus_b.rvalid, bus_c.rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_rvalid got %b want 000", {bus_a.rvalid, bus_b.rvalid, bus_c.rvalid});
        end
        n_cmp++;
        if ((bus_a.rdata | bus_b.rdata | bus_c.rdata) !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rdata got %h want 0", bus_a.rdata | bus_b.rdata | bus_c.rdata);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.ready, bus_b.ready, bus_c.ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL release_ready got %b want 111", {bus_a.ready, bus_b.ready, bus_c.ready});
        end
        @(negedge clk);
        select_dut(0);
        repeat (4) step(1'b0, '0, '0, '0, acc);
    endtask

    task automatic test_write_read();
        bit acc;
        select_dut(0);
        step(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
        n_cmp++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_rsp got rvalid=%b rdata=%h want rvalid=1 rdata=0", obs_rvalid, obs_rdata);
        end
        step(1'b1, 32'h10, 32'h0, 4'h0, acc);
        n_cmp++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_rsp got rvalid=%b rdata=%h want rvalid=1 rdata=deadbeef",
                     obs_rvalid, obs_rdata);
        end
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_byte_mask();
        logic [31:0] got = '0;
        bit          acc;
        select_dut(0);
        issue(32'h20, 32'h11223344, 4'hF);
        issue(32'h20, 32'hAABBCCDD, 4'b0101);
        issue(32'h20, 32'h0, 4'h0);
        got = obs_rdata;
        n_cmp++;
        if (got !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL byte_mask got %h want 11bb33dd", got);
        end
        step(1'b0, '0, '0, '0, acc);
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        select_dut(0);
        d = $urandom;
        issue(32'h0000, d, 4'hF);
        issue(32'h1000, 32'h0, 4'h0);
        n_cmp++;
        if (obs_rdata !== d) begin
            n_fail++;
            $display("FAIL wrap got %h want %h", obs_rdata, d);
        end
        issue(32'h0003, 32'h0, 4'h0);
        n_cmp++;
        if (obs_rdata !== d) begin
            n_fail++;
            $display("FAIL low_bits got %h want %h", obs_rdata, d);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bit acc;
        select_dut(0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'(k * 4), 32'h0, 4'h0, acc);
            n_cmp++;
            if (obs_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_rvalid k=%0d got %b want 1", k, obs_rvalid);
            end
        end
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_random();
        bit          acc;
        logic [31:0] addr;
        logic [3:0]  m;
        select_dut(0);
        for (int w = 0; w < 16; w++) issue(32'(w * 4), $urandom, 4'hF);
        for (int k = 0; k < 400; k++) begin
            addr = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 15) * 4) |
                   32'($urandom_range(0, 3));
            m    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            step($urandom_range(0, 9) < 7, addr, $urandom, m, acc);
        end
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_flow();
        bit        acc;
        int        n_acc = 0;
        logic [7:0] hist = '0;
        select_dut(1);
        for (int w = 0; w < 6; w++) issue(32'(w * 4), 32'hC0DE0000 + 32'(w), 4'hF);
        drain();
        n_rsp = 0;
        for (int k = 0; k < 40 && n_acc < 6; k++) begin
            if (obs_rvalid === 1'b1) begin
                n_cmp++;
                if (obs_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL refill_ready k=%0d got %b want 1", k, obs_ready);
                end
            end
            step(1'b1, 32'(n_acc * 4), 32'h0, 4'h0, acc);
            if (k < 8) hist[k] = acc;
            if (acc) n_acc++;
        end
        req_valid = 1'b0;
        drain();
        n_cmp++;
        if (hist !== 8'b11011011) begin
            n_fail++;
            $display("FAIL accept_pattern got %b want 11011011", hist);
        end
        n_cmp++;
        if (n_rsp != 6) begin
            n_fail++;
            $display("FAIL flow_rsp_count got %0d want 6", n_rsp);
        end
    endtask

    task automatic test_reset_mid();
        bit          acc;
        logic [31:0] got = '0;
        bit          seen = 1'b0;
        int          n_rv = 0;
        select_dut(2);
        issue(32'h40, 32'h55AA1234, 4'hF);
        drain();
        for (int k = 0; k < 3; k++) step(1'b1, 32'h40, 32'h0, 4'h0, acc);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_ready !== 1'b0 || obs_rvalid !== 1'b0 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_state got ready=%b rvalid=%b rdata=%h want 0 0 0",
                     obs_ready, obs_rvalid, obs_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        n_cmp++;
        if (u_c.cnt_q !== '0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release got cnt=%0d ready=%b want cnt=0 ready=1",
                     u_c.cnt_q, obs_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (obs_rvalid === 1'b1) n_rv++;
            step(1'b0, '0, '0, '0, acc);
        end
        n_cmp++;
        if (n_rv != 0) begin
            n_fail++;
            $display("FAIL dropped_rsp got %0d rvalid pulses want 0", n_rv);
        end
        issue(32'h40, 32'h0, 4'h0);
        for (int k = 0; k < 10 && !seen; k++) begin
            if (obs_rvalid === 1'b1) begin
                seen = 1'b1;
                got  = obs_rdata;
            end else begin
                step(1'b0, '0, '0, '0, acc);
            end
        end
        n_cmp++;
        if (!seen || got !== 32'h55AA1234) begin
            n_fail++;
            $display("FAIL persist got seen=%b rdata=%h want seen=1 rdata=55aa1234", seen, got);
        end
        drain();
    endtask

    initial begin
        n_cmp = 0;  n_fail = 0;  n_rsp = 0;  cyc = 0;
        req_valid = 1'b0;
        req = '0;
        select_dut(0);
        test_reset();
        test_write_read();
        test_byte_mask();
        test_wrap();
        test_back_to_back();
        test_random();
        test_flow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
